// File: rtl/updown_counter_ctrl.sv
// rtl/updown_counter_ctrl.sv - prescaled up/down counter with load, programmable top, wrap/saturate
module updown_counter_ctrl #(
    parameter int BW     = 8,
    parameter int PRE_BW = 4
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              nrstSync_i,
    input  logic              en_i,
    input  logic              dir_i,
    input  logic              mode_i,
    input  logic              load_i,
    input  logic [BW-1:0]     load_val_i,
    input  logic [BW-1:0]     top_i,
    input  logic [PRE_BW-1:0] prescale_i,
    output logic [BW-1:0]     count_o,
    output logic              tc_o,
    output logic              sat_o
);

    localparam logic [BW-1:0]     CNT_ONE = BW'(1);
    localparam logic [PRE_BW-1:0] PRE_ONE = PRE_BW'(1);

    logic [BW-1:0]     count_q, count_d;
    logic [PRE_BW-1:0] pre_q, pre_d;
    logic              tc_q, tc_d;
    logic              sat_q, sat_d;

    logic              step;
    logic              at_top;
    logic              at_zero;
    logic [BW-1:0]     load_clamped;

    // >= rather than == so a prescale_i lowered below the current phase steps at once
    assign step         = (pre_q >= prescale_i);
    assign at_top       = (count_q >= top_i);
    assign at_zero      = (count_q == '0);
    assign load_clamped = (load_val_i > top_i) ? top_i : load_val_i;

    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        tc_d    = 1'b0;
        sat_d   = sat_q;

        if (!nrstSync_i) begin
            count_d = '0;
            pre_d   = '0;
            sat_d   = 1'b0;
        end else if (load_i) begin
            count_d = load_clamped;
            pre_d   = '0;
            sat_d   = 1'b0;
        end else if (en_i) begin
            if (!step) begin
                pre_d = pre_q + PRE_ONE;
            end else begin
                pre_d = '0;
                if (dir_i) begin
                    if (!at_top) begin
                        count_d = count_q + CNT_ONE;
                        sat_d   = 1'b0;
                    end else if (!mode_i) begin
                        count_d = '0;
                        tc_d    = 1'b1;
                        sat_d   = 1'b0;
                    end else begin
                        // Saturating re-clamps to a possibly shrunk top; tc only on entry
                        count_d = top_i;
                        sat_d   = 1'b1;
                        tc_d    = !sat_q;
                    end
                end else begin
                    if (!at_zero) begin
                        count_d = count_q - CNT_ONE;
                        sat_d   = 1'b0;
                    end else if (!mode_i) begin
                        count_d = top_i;
                        tc_d    = 1'b1;
                        sat_d   = 1'b0;
                    end else begin
                        count_d = '0;
                        sat_d   = 1'b1;
                        tc_d    = !sat_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            count_q <= '0;
            pre_q   <= '0;
            tc_q    <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
            sat_q   <= sat_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign sat_o   = sat_q;

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// tb/tb_updown_counter_ctrl.sv - scoreboard bench for updown_counter_ctrl
module tb_updown_counter_ctrl;

    logic       clk_i = 1'b0;
    logic       nrst_i;
    logic       nrstSync_i;
    logic       en_i;
    logic       dir_i;
    logic       mode_i;
    logic       load_i;
    logic [7:0] load_val_i;
    logic [7:0] top_i;
    logic [3:0] prescale_i;
    logic [7:0] count_o;
    logic       tc_o;
    logic       sat_o;

    typedef struct {
        logic [7:0] c;
        logic       tc;
        logic       sat;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    updown_counter_ctrl #(.BW(8), .PRE_BW(4)) dut (
        .clk_i      (clk_i),
        .nrst_i     (nrst_i),
        .nrstSync_i (nrstSync_i),
        .en_i       (en_i),
        .dir_i      (dir_i),
        .mode_i     (mode_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .top_i      (top_i),
        .prescale_i (prescale_i),
        .count_o    (count_o),
        .tc_o       (tc_o),
        .sat_o      (sat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One vector: inputs applied at negedge, expected result of the following posedge queued
    task automatic vec(input string tag, input logic srst_n, input logic ld, input logic [7:0] lv,
                       input logic en, input logic dir, input logic mode, input logic [7:0] top,
                       input logic [3:0] pre, input logic [7:0] ec, input logic etc, input logic esat);
        exp_t e;
        @(negedge clk_i);
        nrstSync_i = srst_n;
        load_i     = ld;
        load_val_i = lv;
        en_i       = en;
        dir_i      = dir;
        mode_i     = mode;
        top_i      = top;
        prescale_i = pre;
        e.c = ec; e.tc = etc; e.sat = esat; e.tag = tag;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, "_count"}, int'(count_o), int'(e.c));
                chk({e.tag, "_tc"},    int'(tc_o),    int'(e.tc));
                chk({e.tag, "_sat"},   int'(sat_o),   int'(e.sat));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int seq[5];
        int prev;
        nrst_i = 1'b0; nrstSync_i = 1'b1; en_i = 1'b0; dir_i = 1'b1; mode_i = 1'b0;
        load_i = 1'b0; load_val_i = 8'd0; top_i = 8'd0; prescale_i = 4'd0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_count", int'(count_o), 0);
        chk("reset_tc",    int'(tc_o),    0);
        chk("reset_sat",   int'(sat_o),   0);
        @(negedge clk_i);
        nrst_i = 1'b1;

        // Wrap up, top 9, period 10
        vec("clr1", 0, 0, 0, 0, 1, 0, 9, 0, 0, 0, 0);
        for (int i = 1; i <= 21; i++)
            vec("wrapup", 1, 0, 0, 1, 1, 0, 9, 0, 8'(i % 10), (i % 10) == 0, 0);

        // Down wrap with prescale 2: steps 3,2,1,0,3 every third clock
        vec("clr2", 0, 0, 0, 0, 1, 0, 3, 2, 0, 0, 0);
        seq = '{3, 2, 1, 0, 3};
        prev = 0;
        for (int s = 0; s < 5; s++) begin
            vec("dnhold", 1, 0, 0, 1, 0, 0, 3, 2, 8'(prev), 0, 0);
            vec("dnhold", 1, 0, 0, 1, 0, 0, 3, 2, 8'(prev), 0, 0);
            vec("dnstep", 1, 0, 0, 1, 0, 0, 3, 2, 8'(seq[s]), seq[s] == 3, 0);
            prev = seq[s];
        end

        // Saturate up at 5, then down, then saturate at 0
        vec("clr3", 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            vec("satup", 1, 0, 0, 1, 1, 1, 5, 0, 8'(i), 0, 0);
        vec("satenter", 1, 0, 0, 1, 1, 1, 5, 0, 5, 1, 1);
        vec("satheld",  1, 0, 0, 1, 1, 1, 5, 0, 5, 0, 1);
        vec("satheld",  1, 0, 0, 1, 1, 1, 5, 0, 5, 0, 1);
        for (int i = 4; i >= 0; i--)
            vec("satdown", 1, 0, 0, 1, 0, 1, 5, 0, 8'(i), 0, 0);
        vec("sat0enter", 1, 0, 0, 1, 0, 1, 5, 0, 0, 1, 1);
        vec("sat0held",  1, 0, 0, 1, 0, 1, 5, 0, 0, 0, 1);

        // Load clamp, clear over load, load while disabled
        vec("loadclamp", 1, 1, 200, 1, 1, 0, 100, 0, 100, 0, 0);
        vec("clrload",   0, 1, 200, 1, 1, 0, 100, 0, 0, 0, 0);
        vec("loaddis",   1, 1, 42, 0, 1, 0, 100, 0, 42, 0, 0);
        vec("holddis",   1, 0, 42, 0, 1, 0, 100, 0, 42, 0, 0);
        vec("afterload", 1, 0, 0, 1, 1, 0, 100, 0, 43, 0, 0);

        // Prescale lowered below the current phase steps immediately
        vec("clr4", 0, 0, 0, 0, 1, 0, 100, 5, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            vec("pre5", 1, 0, 0, 1, 1, 0, 100, 5, 0, 0, 0);
        vec("prelow",  1, 0, 0, 1, 1, 0, 100, 1, 1, 0, 0);
        vec("pre1a",   1, 0, 0, 1, 1, 0, 100, 1, 1, 0, 0);
        vec("pre1b",   1, 0, 0, 1, 1, 0, 100, 1, 2, 0, 0);

        // Top shrink below count, wrap mode then saturate mode
        vec("ld50",     1, 1, 50, 0, 1, 0, 100, 0, 50, 0, 0);
        vec("up51",     1, 0, 0, 1, 1, 0, 100, 0, 51, 0, 0);
        vec("shrinkw",  1, 0, 0, 1, 1, 0, 20, 0, 0, 1, 0);
        vec("endis",    1, 0, 0, 0, 1, 0, 20, 0, 0, 0, 0);
        vec("afterw",   1, 0, 0, 1, 1, 0, 20, 0, 1, 0, 0);
        vec("ld50s",    1, 1, 50, 0, 1, 1, 100, 0, 50, 0, 0);
        vec("shrinks",  1, 0, 0, 1, 1, 1, 20, 0, 20, 1, 1);
        vec("shrinkh",  1, 0, 0, 1, 1, 1, 20, 0, 20, 0, 1);
        vec("shrink2",  1, 0, 0, 1, 1, 1, 10, 0, 10, 0, 1);

        // Async reset mid-count
        vec("ld37",  1, 1, 8'h37, 0, 1, 0, 255, 0, 8'h37, 0, 0);
        vec("up38",  1, 0, 0, 1, 1, 0, 255, 0, 8'h38, 0, 0);
        vec("up39",  1, 0, 0, 1, 1, 0, 255, 0, 8'h39, 0, 0);
        @(posedge clk_i);
        #3;
        nrst_i = 1'b0;
        #1;
        chk("async_count", int'(count_o), 0);
        chk("async_tc",    int'(tc_o),    0);
        chk("async_sat",   int'(sat_o),   0);
        en_i = 1'b0;
        load_i = 1'b0;
        @(negedge clk_i);
        nrst_i = 1'b1;
        vec("postrst", 1, 0, 0, 1, 1, 0, 255, 0, 1, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk_i);
        #2;
        chk("drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
